// File: rtl/program_counter.sv
// Architectural program-counter register for the fetch stage.
// Loads the next PC each edge unless a hazard or cache stall holds it.
module program_counter #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  PcWriteEn,
    input  logic                  InstCacheEn,
    input  logic                  DataCacheEn,
    input  logic [DATA_WIDTH-1:0] PcInput,
    output logic [DATA_WIDTH-1:0] PcOutput
);

    logic                  stall;
    logic [DATA_WIDTH-1:0] pc_d;
    logic [DATA_WIDTH-1:0] pc_q;

    // PcWriteEn is a hold request despite its name; all three stalls weigh equally.
    assign stall = PcWriteEn | InstCacheEn | DataCacheEn;

    always_comb begin
        pc_d = pc_q;
        if (!stall) begin
            pc_d = PcInput;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PcOutput = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios plus a
// randomized run checked against a cycle-level reference model.
module tb_program_counter;

    localparam int          W     = 32;
    localparam logic [W-1:0] RST_V = 32'h0000_0000;

    logic         clk;
    logic         reset;
    logic         PcWriteEn;
    logic         InstCacheEn;
    logic         DataCacheEn;
    logic [W-1:0] PcInput;
    logic [W-1:0] PcOutput;

    int errors;
    int checks;

    // Reference model state: the architectural PC as the spec defines it.
    logic [W-1:0] model_pc;
    logic [W-1:0] exp_q[$];

    program_counter #(
        .DATA_WIDTH  (W),
        .RESET_VECTOR(RST_V)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .PcWriteEn  (PcWriteEn),
        .InstCacheEn(InstCacheEn),
        .DataCacheEn(DataCacheEn),
        .PcInput    (PcInput),
        .PcOutput   (PcOutput)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance one edge, queue the expected PC.
    task automatic drive_cycle(input logic rst, input logic pwe, input logic ice,
                               input logic dce, input logic [W-1:0] pc_in);
        reset       = rst;
        PcWriteEn   = pwe;
        InstCacheEn = ice;
        DataCacheEn = dce;
        PcInput     = pc_in;
        if (rst)
            model_pc = RST_V;
        else if (pwe || ice || dce)
            model_pc = model_pc;
        else
            model_pc = pc_in;
        exp_q.push_back(model_pc);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] exp;
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        exp = exp_q.pop_front();
        checks++;
        if (PcOutput !== exp) begin
            errors++;
            $display("FAIL reset_value: got %h expected %h", PcOutput, exp);
        end
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        exp = exp_q.pop_front();
        checks++;
        if (PcOutput !== exp) begin
            errors++;
            $display("FAIL reset_release_hold: got %h expected %h", PcOutput, exp);
        end
    endtask

    task automatic test_load();
        logic [W-1:0] exp;
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h1234_5678);
        exp = exp_q.pop_front();
        checks++;
        if (PcOutput !== 32'h1234_5678 || PcOutput !== exp) begin
            errors++;
            $display("FAIL load: got %h expected %h", PcOutput, exp);
        end
    endtask

    task automatic test_stall_single();
        logic [W-1:0] vals [3];
        logic [W-1:0] exp;
        vals[0] = 32'h8765_4321;
        vals[1] = 32'hAAAA_BBBB;
        vals[2] = 32'hCCCC_DDDD;
        for (int s = 0; s < 3; s++) begin
            drive_cycle(1'b0, s == 0, s == 1, s == 2, vals[s]);
            exp = exp_q.pop_front();
            checks++;
            if (PcOutput !== 32'h1234_5678 || PcOutput !== exp) begin
                errors++;
                $display("FAIL stall_src%0d: got %h expected %h", s, PcOutput, exp);
            end
        end
    endtask

    task automatic test_stall_multi();
        logic [W-1:0] exp;
        logic [2:0]   combo;
        // Pairs of sources, then all three.
        for (int c = 0; c < 4; c++) begin
            combo = (c == 0) ? 3'b011 : (c == 1) ? 3'b101 : (c == 2) ? 3'b110 : 3'b111;
            drive_cycle(1'b0, combo[0], combo[1], combo[2], 32'h1111_2222);
            exp = exp_q.pop_front();
            checks++;
            if (PcOutput !== 32'h1234_5678 || PcOutput !== exp) begin
                errors++;
                $display("FAIL stall_combo_%b: got %h expected %h", combo, PcOutput, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp;
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1111);
        exp = exp_q.pop_front();
        checks++;
        if (PcOutput !== 32'h0000_1111 || PcOutput !== exp) begin
            errors++;
            $display("FAIL b2b_first: got %h expected %h", PcOutput, exp);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_2222);
        exp = exp_q.pop_front();
        checks++;
        if (PcOutput !== 32'h0000_2222 || PcOutput !== exp) begin
            errors++;
            $display("FAIL b2b_second: got %h expected %h", PcOutput, exp);
        end
    endtask

    task automatic test_reset_mid_stall();
        logic [W-1:0] exp;
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
        exp = exp_q.pop_front();
        checks++;
        if (PcOutput !== 32'h0000_0000 || PcOutput !== exp) begin
            errors++;
            $display("FAIL reset_mid_stall: got %h expected %h", PcOutput, exp);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] exp;
        logic         r, a, b, c;
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 19) == 0);
            a = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 3) == 0);
            drive_cycle(r, a, b, c, $urandom);
            exp = exp_q.pop_front();
            checks++;
            if (PcOutput !== exp) begin
                errors++;
                $display("FAIL random_%0d: got %h expected %h (rst=%b stalls=%b%b%b)",
                         i, PcOutput, exp, r, a, b, c);
            end
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        model_pc    = '0;
        reset       = 1'b0;
        PcWriteEn   = 1'b0;
        InstCacheEn = 1'b0;
        DataCacheEn = 1'b0;
        PcInput     = '0;
        @(negedge clk);

        test_reset();
        test_load();
        test_stall_single();
        test_stall_multi();
        test_back_to_back();
        test_reset_mid_stall();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
